// File: rtl/ipml_fifo_pkg.sv
// Shared configuration helpers for the prefetch FIFO write-side packer.
// Holds the legality check, the pack_cnt width function and the default pad value.
package ipml_fifo_pkg;

  localparam int unsigned PackPadDefault = 0;
  localparam int unsigned PackRatioMin   = 2;
  localparam int unsigned PackRatioMax   = 16;

  function automatic int unsigned pack_cnt_width(input int unsigned ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  function automatic bit pack_cfg_ok(input int unsigned in_w, input int unsigned ratio,
                                     input int unsigned wr_w, input int unsigned cnt_w);
    return (in_w > 0) && (ratio >= PackRatioMin) && (ratio <= PackRatioMax) &&
           (wr_w == in_w * ratio) && (cnt_w > 0);
  endfunction

endpackage

// File: rtl/ipml_wr_pack_acc.sv
// Beat accumulator and slot counter for the write-side packer.
// With IPML_PACKER_PAD_EN defined, a beat flagged last closes the word and pads the upper slots.
module ipml_wr_pack_acc import ipml_fifo_pkg::*; #(
  parameter int unsigned                 c_IN_DATA_WIDTH = 8,
  parameter int unsigned                 c_PACK_RATIO    = 4,
  parameter logic [c_IN_DATA_WIDTH-1:0]  c_PAD_VALUE     = '0,
  localparam int unsigned                CntW            = pack_cnt_width(c_PACK_RATIO),
  localparam int unsigned                WordW           = c_IN_DATA_WIDTH * c_PACK_RATIO
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [c_IN_DATA_WIDTH-1:0] beat_data_i,
  input  logic                       beat_fire_i,
  input  logic                       beat_last_i,
  output logic [CntW-1:0]            pack_cnt_o,
  output logic                       word_done_o,
  output logic [WordW-1:0]           word_data_o
);

  localparam logic [CntW-1:0] LastSlot = CntW'(c_PACK_RATIO - 1);

  logic [WordW-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Current accumulator with the presented beat merged in; only consumed on an accepted beat.
  always_comb begin
    word_data_o = acc_q;
    for (int k = 0; k < int'(c_PACK_RATIO); k++) begin
      if (CntW'(k) == cnt_q) begin
        word_data_o[k*c_IN_DATA_WIDTH +: c_IN_DATA_WIDTH] = beat_data_i;
      end
`ifdef IPML_PACKER_PAD_EN
      else if (beat_last_i && (CntW'(k) > cnt_q)) begin
        word_data_o[k*c_IN_DATA_WIDTH +: c_IN_DATA_WIDTH] = c_PAD_VALUE;
      end
`endif
    end
  end

`ifdef IPML_PACKER_PAD_EN
  assign word_done_o = beat_fire_i & ((cnt_q == LastSlot) | beat_last_i);
`else
  logic [c_IN_DATA_WIDTH:0] unused_pad;
  assign unused_pad  = {beat_last_i, c_PAD_VALUE};
  assign word_done_o = beat_fire_i & (cnt_q == LastSlot);
`endif

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (word_done_o) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (beat_fire_i) begin
      acc_d = word_data_o;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign pack_cnt_o = cnt_q;

endmodule

// File: rtl/ipml_fifo_wr_packer_v1_0.sv
// Write-side producer for the prefetch FIFO: packs narrow beats into FIFO words.
// Optional feature macro: IPML_PACKER_PAD_EN (in_last flushes a partial, padded word).
module ipml_fifo_wr_packer_v1_0 import ipml_fifo_pkg::*; #(
  parameter int unsigned                c_IN_DATA_WIDTH = 8,
  parameter int unsigned                c_PACK_RATIO    = 4,
  parameter int unsigned                c_WR_DATA_WIDTH = 32,
  parameter logic [c_IN_DATA_WIDTH-1:0] c_PAD_VALUE     = c_IN_DATA_WIDTH'(PackPadDefault),
  parameter int unsigned                c_CNT_WIDTH     = 16,
  localparam int unsigned               CntW            = pack_cnt_width(c_PACK_RATIO)
) (
  input  logic                       wr_clk,
  input  logic                       wr_rst,
  input  logic [c_IN_DATA_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [c_WR_DATA_WIDTH-1:0] wr_data,
  output logic                       wr_en,
  input  logic                       wr_vld,
  output logic [CntW-1:0]            pack_cnt,
  output logic [c_CNT_WIDTH-1:0]     word_cnt
);

  if (!pack_cfg_ok(c_IN_DATA_WIDTH, c_PACK_RATIO, c_WR_DATA_WIDTH, c_CNT_WIDTH)) begin : g_cfg_err
    $error("ipml_fifo_wr_packer_v1_0: illegal packer configuration");
  end

  logic                       beat_fire;
  logic                       word_done;
  logic [c_WR_DATA_WIDTH-1:0] word_data;

  logic                       out_vld_q, out_vld_d;
  logic [c_WR_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [c_CNT_WIDTH-1:0]     word_cnt_q, word_cnt_d;

  ipml_wr_pack_acc #(
    .c_IN_DATA_WIDTH (c_IN_DATA_WIDTH),
    .c_PACK_RATIO    (c_PACK_RATIO),
    .c_PAD_VALUE     (c_PAD_VALUE)
  ) u_acc (
    .clk_i       (wr_clk),
    .rst_i       (wr_rst),
    .beat_data_i (in_data),
    .beat_fire_i (beat_fire),
    .beat_last_i (in_last),
    .pack_cnt_o  (pack_cnt),
    .word_done_o (word_done),
    .word_data_o (word_data)
  );

  assign wr_en     = out_vld_q & wr_vld;
  assign beat_fire = in_valid & in_ready;

`ifdef IPML_PACKER_PAD_EN
  assign in_ready = ~wr_rst & (~out_vld_q | wr_vld);
`else
  localparam logic [CntW-1:0] LastSlot = CntW'(c_PACK_RATIO - 1);
  // Only the word-completing beat needs a free output register.
  assign in_ready = ~wr_rst & (~out_vld_q | wr_vld | (pack_cnt != LastSlot));
`endif

  always_comb begin
    out_vld_d  = out_vld_q & ~wr_en;
    wr_data_d  = wr_data_q;
    word_cnt_d = word_cnt_q + c_CNT_WIDTH'(wr_en);
    if (word_done) begin
      out_vld_d = 1'b1;
      wr_data_d = word_data;
    end
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      out_vld_q  <= 1'b0;
      wr_data_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      wr_data_q  <= wr_data_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign wr_data  = wr_data_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_ipml_fifo_wr_packer_v1_0.sv
// Directed bench for ipml_fifo_wr_packer_v1_0; a second small instance exercises word_cnt wrap.
module tb_ipml_fifo_wr_packer_v1_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_ready;
  logic [31:0] wr_data;
  logic        wr_en, wr_vld;
  logic [1:0]  pack_cnt;
  logic [15:0] word_cnt;

  logic [7:0]  w_in_data;
  logic        w_in_valid, w_in_last, w_in_ready;
  logic [15:0] w_wr_data;
  logic        w_wr_en, w_wr_vld;
  logic        w_pack_cnt;
  logic [2:0]  w_word_cnt;

  ipml_fifo_wr_packer_v1_0 #(
    .c_IN_DATA_WIDTH (8),
    .c_PACK_RATIO    (4),
    .c_WR_DATA_WIDTH (32),
    .c_PAD_VALUE     (8'hEE),
    .c_CNT_WIDTH     (16)
  ) dut (
    .wr_clk   (clk),
    .wr_rst   (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .wr_vld   (wr_vld),
    .pack_cnt (pack_cnt),
    .word_cnt (word_cnt)
  );

  ipml_fifo_wr_packer_v1_0 #(
    .c_IN_DATA_WIDTH (8),
    .c_PACK_RATIO    (2),
    .c_WR_DATA_WIDTH (16),
    .c_PAD_VALUE     (8'h00),
    .c_CNT_WIDTH     (3)
  ) u_wrap (
    .wr_clk   (clk),
    .wr_rst   (rst),
    .in_data  (w_in_data),
    .in_valid (w_in_valid),
    .in_last  (w_in_last),
    .in_ready (w_in_ready),
    .wr_data  (w_wr_data),
    .wr_en    (w_wr_en),
    .wr_vld   (w_wr_vld),
    .pack_cnt (w_pack_cnt),
    .word_cnt (w_word_cnt)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int unsigned exp_words = 0;
  logic [31:0] wr_log[$];
  int          wr_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // wr_en/wr_data are stable between posedge+1 and the next posedge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_log.push_back(wr_data);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int budget = 50;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (in_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_tests++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL beat_accept: in_ready stayed %b for beat %h, required 1", in_ready, d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b0; wr_vld = 1'b1;
    w_in_valid = 1'b0; w_in_data = 8'h00; w_in_last = 1'b0; w_wr_vld = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
    n_tests++; if (wr_en !== 1'b0) begin n_fail++;
      $display("FAIL rst_wr_en: got %b exp 0", wr_en); end
    n_tests++; if (pack_cnt !== 2'd0) begin n_fail++;
      $display("FAIL rst_pack_cnt: got %0d exp 0", pack_cnt); end
    n_tests++; if (word_cnt !== 16'd0) begin n_fail++;
      $display("FAIL rst_word_cnt: got %0d exp 0", word_cnt); end
    n_tests++; if (wr_data !== 32'h0) begin n_fail++;
      $display("FAIL rst_wr_data: got %h exp 0", wr_data); end
    @(posedge clk); #1;
    in_valid = 1'b0; wr_vld = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    wr_log.delete(); wr_cyc.delete();
    wr_vld = 1'b1;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b0);
    @(negedge clk);
    n_tests++; if (wr_en !== 1'b1) begin n_fail++;
      $display("FAIL single_wr_en: got %b exp 1", wr_en); end
    n_tests++; if (wr_data !== 32'h44332211) begin n_fail++;
      $display("FAIL single_wr_data: got %h exp 44332211", wr_data); end
    n_tests++; if (pack_cnt !== 2'd0) begin n_fail++;
      $display("FAIL single_pack_cnt: got %0d exp 0", pack_cnt); end
    n_tests++; if (word_cnt !== 16'd0) begin n_fail++;
      $display("FAIL single_word_cnt_pre: got %0d exp 0", word_cnt); end
    tick();
    @(negedge clk);
    exp_words = 1;
    n_tests++; if (wr_en !== 1'b0) begin n_fail++;
      $display("FAIL single_wr_en_after: got %b exp 0", wr_en); end
    n_tests++; if (word_cnt !== 16'(exp_words)) begin n_fail++;
      $display("FAIL single_word_cnt: got %0d exp %0d", word_cnt, exp_words); end
    n_tests++; if (wr_log.size() != 1) begin n_fail++;
      $display("FAIL single_write_count: got %0d exp 1", wr_log.size()); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    int rdy_low = 0;
    wr_log.delete(); wr_cyc.delete();
    wr_vld = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      @(negedge clk);
      if (in_ready !== 1'b1) rdy_low++;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    exp_words += 4;
    n_tests++; if (rdy_low != 0) begin n_fail++;
      $display("FAIL b2b_in_ready: low on %0d cycles, exp 0", rdy_low); end
    n_tests++; if (wr_log.size() != 4) begin n_fail++;
      $display("FAIL b2b_write_count: got %0d exp 4", wr_log.size()); end
    for (int j = 0; j < 4 && j < wr_log.size(); j++) begin
      n_tests++; if (wr_log[j] !== exp_w[j]) begin n_fail++;
        $display("FAIL b2b_word%0d: got %h exp %h", j, wr_log[j], exp_w[j]); end
    end
    for (int j = 1; j < wr_cyc.size(); j++) begin
      n_tests++; if (wr_cyc[j] - wr_cyc[j-1] != 4) begin n_fail++;
        $display("FAIL b2b_spacing%0d: got %0d cycles exp 4", j, wr_cyc[j] - wr_cyc[j-1]); end
    end
    @(negedge clk);
    n_tests++; if (word_cnt !== 16'(exp_words)) begin n_fail++;
      $display("FAIL b2b_word_cnt: got %0d exp %0d", word_cnt, exp_words); end
    tick();
  endtask

  task automatic test_backpressure();
    wr_log.delete(); wr_cyc.delete();
    wr_vld = 1'b1;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b0);
    wr_vld = 1'b0;
`ifdef IPML_PACKER_PAD_EN
    in_valid = 1'b1; in_data = 8'h55;
    repeat (2) begin
      @(negedge clk);
      n_tests++; if (in_ready !== 1'b0) begin n_fail++;
        $display("FAIL bp_pad_in_ready: got %b exp 0", in_ready); end
      n_tests++; if (wr_data !== 32'h44332211) begin n_fail++;
        $display("FAIL bp_pad_hold: got %h exp 44332211", wr_data); end
      tick();
    end
    in_valid = 1'b0;
    wr_vld = 1'b1;
    @(negedge clk);
    n_tests++; if (wr_en !== 1'b1) begin n_fail++;
      $display("FAIL bp_pad_wr_en: got %b exp 1", wr_en); end
    tick();
    exp_words += 1;
`else
    send_beat(8'h55, 1'b0);
    send_beat(8'h66, 1'b0);
    send_beat(8'h77, 1'b0);
    @(negedge clk);
    n_tests++; if (wr_data !== 32'h44332211) begin n_fail++;
      $display("FAIL bp_hold: got %h exp 44332211", wr_data); end
    n_tests++; if (wr_en !== 1'b0) begin n_fail++;
      $display("FAIL bp_wr_en_low: got %b exp 0", wr_en); end
    n_tests++; if (pack_cnt !== 2'd3) begin n_fail++;
      $display("FAIL bp_pack_cnt: got %0d exp 3", pack_cnt); end
    tick();
    in_valid = 1'b1; in_data = 8'h88;
    repeat (2) begin
      @(negedge clk);
      n_tests++; if (in_ready !== 1'b0) begin n_fail++;
        $display("FAIL bp_stall: in_ready got %b exp 0", in_ready); end
      tick();
    end
    n_tests++; if (wr_log.size() != 0) begin n_fail++;
      $display("FAIL bp_no_write: got %0d writes exp 0", wr_log.size()); end
    wr_vld = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL bp_release_ready: got %b exp 1", in_ready); end
    n_tests++; if (wr_en !== 1'b1) begin n_fail++;
      $display("FAIL bp_release_wr_en: got %b exp 1", wr_en); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (wr_data !== 32'h88776655) begin n_fail++;
      $display("FAIL bp_second_word: got %h exp 88776655", wr_data); end
    n_tests++; if (wr_en !== 1'b1 || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL bp_second_write: wr_en %b in_ready %b exp 1 1", wr_en, in_ready); end
    tick();
    n_tests++; if (wr_log.size() != 2 || wr_log[0] !== 32'h44332211) begin n_fail++;
      $display("FAIL bp_log: got %0d writes, first %h exp 2, 44332211",
               wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 32'h0); end
    exp_words += 2;
`endif
    @(negedge clk);
    n_tests++; if (word_cnt !== 16'(exp_words)) begin n_fail++;
      $display("FAIL bp_word_cnt: got %0d exp %0d", word_cnt, exp_words); end
    tick();
  endtask

  task automatic test_pad_flush();
    wr_log.delete(); wr_cyc.delete();
    wr_vld = 1'b1;
    send_beat(8'hA1, 1'b0);
    send_beat(8'hA2, 1'b1);
    @(negedge clk);
`ifdef IPML_PACKER_PAD_EN
    n_tests++; if (wr_en !== 1'b1) begin n_fail++;
      $display("FAIL pad_wr_en: got %b exp 1", wr_en); end
    n_tests++; if (wr_data !== 32'hEEEEA2A1) begin n_fail++;
      $display("FAIL pad_wr_data: got %h exp EEEEA2A1", wr_data); end
    n_tests++; if (pack_cnt !== 2'd0) begin n_fail++;
      $display("FAIL pad_pack_cnt: got %0d exp 0", pack_cnt); end
    tick();
`else
    n_tests++; if (wr_en !== 1'b0) begin n_fail++;
      $display("FAIL nopad_wr_en: got %b exp 0", wr_en); end
    n_tests++; if (pack_cnt !== 2'd2) begin n_fail++;
      $display("FAIL nopad_pack_cnt: got %0d exp 2", pack_cnt); end
    repeat (2) tick();
    n_tests++; if (wr_log.size() != 0) begin n_fail++;
      $display("FAIL nopad_no_write: got %0d writes exp 0", wr_log.size()); end
    send_beat(8'hA3, 1'b0);
    send_beat(8'hA4, 1'b0);
    @(negedge clk);
    n_tests++; if (wr_en !== 1'b1 || wr_data !== 32'hA4A3A2A1) begin n_fail++;
      $display("FAIL nopad_word: wr_en %b data %h exp 1 A4A3A2A1", wr_en, wr_data); end
    tick();
`endif
    exp_words += 1;
    @(negedge clk);
    n_tests++; if (word_cnt !== 16'(exp_words)) begin n_fail++;
      $display("FAIL pad_word_cnt: got %0d exp %0d", word_cnt, exp_words); end
    tick();
  endtask

  task automatic test_reset_mid_word();
    wr_vld = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    wr_log.delete(); wr_cyc.delete();
    rst = 1'b1;
    #1;
    n_tests++; if (wr_en !== 1'b0 || in_ready !== 1'b0) begin n_fail++;
      $display("FAIL mid_rst_ctrl: wr_en %b in_ready %b exp 0 0", wr_en, in_ready); end
    n_tests++; if (pack_cnt !== 2'd0 || word_cnt !== 16'd0) begin n_fail++;
      $display("FAIL mid_rst_cnt: pack_cnt %0d word_cnt %0d exp 0 0", pack_cnt, word_cnt); end
    wr_vld = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b0 || wr_en !== 1'b0) begin n_fail++;
      $display("FAIL mid_rst_hold: in_ready %b wr_en %b exp 0 0", in_ready, wr_en); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    exp_words = 0;
    tick();
    n_tests++; if (wr_log.size() != 0) begin n_fail++;
      $display("FAIL mid_rst_no_write: got %0d writes exp 0", wr_log.size()); end
    send_beat(8'h31, 1'b0);
    send_beat(8'h32, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h34, 1'b0);
    @(negedge clk);
    n_tests++; if (wr_en !== 1'b1 || wr_data !== 32'h34333231) begin n_fail++;
      $display("FAIL mid_rst_clean_word: wr_en %b data %h exp 1 34333231", wr_en, wr_data); end
    tick();
    exp_words += 1;
    @(negedge clk);
    n_tests++; if (word_cnt !== 16'(exp_words)) begin n_fail++;
      $display("FAIL mid_rst_word_cnt: got %0d exp %0d", word_cnt, exp_words); end
    tick();
  endtask

  task automatic test_word_cnt_wrap();
    w_wr_vld = 1'b1;
    w_in_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      w_in_data = 8'(i);
      tick();
    end
    w_in_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    n_tests++; if (w_word_cnt !== 3'd7) begin n_fail++;
      $display("FAIL wrap_pre: word_cnt got %0d exp 7", w_word_cnt); end
    n_tests++; if (w_wr_data !== 16'h0D0C) begin n_fail++;
      $display("FAIL wrap_pre_data: got %h exp 0D0C", w_wr_data); end
    tick();
    w_in_valid = 1'b1;
    for (int i = 14; i < 16; i++) begin
      w_in_data = 8'(i);
      tick();
    end
    w_in_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    n_tests++; if (w_word_cnt !== 3'd0) begin n_fail++;
      $display("FAIL wrap_zero: word_cnt got %0d exp 0", w_word_cnt); end
    n_tests++; if (w_wr_data !== 16'h0F0E) begin n_fail++;
      $display("FAIL wrap_data: got %h exp 0F0E", w_wr_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_pad_flush();
    test_reset_mid_word();
    test_word_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
